i2c_bit_timer: RTL and testbench

Parametrised I2C bit-level timing engine, the successor to the fixed 10 MHz SCL generator. It runs on i_clk with internal clock-enable counting and no derived clocks. Timing is computed from CLK_HZ, and three bus speeds are supported. It executes one START, BIT, RESTART or STOP command at a time and drives open-drain SCL/SDA enables, including clock-stretch detection. It sits between the byte/transaction FSM above and the pad tristates below.

---
 rtl/i2c_bit_timer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_i2c_bit_timer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bit_timer.sv
// I2C bit-level timing engine: START/BIT/RESTART/STOP sequencing with open-drain enables and stretch detection.
// Optional REL stretch timeout is compiled in with `define I2C_TIMING_STRETCH_TIMEOUT_EN.
module i2c_bit_timer #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 2_500_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_mode,
    input  logic [2:0] i_cmd,
    input  logic       i_cmd_bit,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_scl_oe,
    output logic       o_sda_oe,
    output logic       o_done,
    output logic       o_rx_bit,
    output logic       o_err,
    output logic       o_bus_owned
);

    // ceil(ns * CLK_HZ / 1e9) in i_clk ticks
    function automatic logic [CNT_W-1:0] ticks(input longint unsigned ns);
        longint unsigned t;
        t = (ns * 64'(CLK_HZ) + 64'd999_999_999) / 64'd1_000_000_000;
        return CNT_W'(t);
    endfunction

    localparam logic [CNT_W-1:0] LOW_SM    = ticks(4700);
    localparam logic [CNT_W-1:0] LOW_FM    = ticks(1300);
    localparam logic [CNT_W-1:0] LOW_FP    = ticks(500);
    localparam logic [CNT_W-1:0] HIGH_SM   = ticks(4000);
    localparam logic [CNT_W-1:0] HIGH_FM   = ticks(600);
    localparam logic [CNT_W-1:0] HIGH_FP   = ticks(260);
    localparam logic [CNT_W-1:0] SUSTA_SM  = ticks(4700);
    localparam logic [CNT_W-1:0] HDSTA_SM  = ticks(4000);
    localparam logic [CNT_W-1:0] SUSTO_SM  = ticks(4000);
    localparam logic [CNT_W-1:0] STA_FM    = ticks(600);
    localparam logic [CNT_W-1:0] STA_FP    = ticks(260);
    localparam logic [CNT_W-1:0] BUF_SM    = ticks(4700);
    localparam logic [CNT_W-1:0] BUF_FM    = ticks(1300);
    localparam logic [CNT_W-1:0] BUF_FP    = ticks(500);
    localparam logic [CNT_W-1:0] HDDAT_SM  = ticks(300);
    localparam logic [CNT_W-1:0] HDDAT_FP  = ticks(120);

    localparam logic [2:0] CMD_START   = 3'd0;
    localparam logic [2:0] CMD_BIT     = 3'd1;
    localparam logic [2:0] CMD_RESTART = 3'd2;
    localparam logic [2:0] CMD_STOP    = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_BUF, S_SU, S_HD, S_LOW, S_REL, S_HIGH, S_PARK
    } state_t;

    typedef enum logic [1:0] {
        OP_START, OP_BIT, OP_RESTART, OP_STOP
    } op_t;

    state_t           state_q;
    op_t              op_q;
    logic [1:0]       mode_q;
    logic             bit_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_q, scl_oe_q, sda_oe_q, done_q, rx_q, err_q, owned_q;
    logic             scl_meta, scl_s, sda_meta, sda_s;

    logic [CNT_W-1:0] t_low, t_high, t_su_sta, t_hd_sta, t_su_sto, t_buf, t_hd_dat, t_su;

`ifdef I2C_TIMING_STRETCH_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TO_W-1:0] to_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYC);
`endif

    // Pad levels are asynchronous; both idle high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_meta <= 1'b1;
            scl_s    <= 1'b1;
            sda_meta <= 1'b1;
            sda_s    <= 1'b1;
        end else begin
            scl_meta <= i_scl;
            scl_s    <= scl_meta;
            sda_meta <= i_sda;
            sda_s    <= sda_meta;
        end
    end

    // Per-mode targets from the latched speed; mode 11 falls back to standard.
    always_comb begin
        t_low    = LOW_SM;
        t_high   = HIGH_SM;
        t_su_sta = SUSTA_SM;
        t_hd_sta = HDSTA_SM;
        t_su_sto = SUSTO_SM;
        t_buf    = BUF_SM;
        t_hd_dat = HDDAT_SM;
        case (mode_q)
            2'b01: begin
                t_low    = LOW_FM;
                t_high   = HIGH_FM;
                t_su_sta = STA_FM;
                t_hd_sta = STA_FM;
                t_su_sto = STA_FM;
                t_buf    = BUF_FM;
            end
            2'b10: begin
                t_low    = LOW_FP;
                t_high   = HIGH_FP;
                t_su_sta = STA_FP;
                t_hd_sta = STA_FP;
                t_su_sto = STA_FP;
                t_buf    = BUF_FP;
                t_hd_dat = HDDAT_FP;
            end
            default: ;
        endcase
        t_su = (op_q == OP_STOP) ? t_su_sto : t_su_sta;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_START;
            mode_q   <= 2'b00;
            bit_q    <= 1'b0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            scl_oe_q <= 1'b0;
            sda_oe_q <= 1'b0;
            done_q   <= 1'b0;
            rx_q     <= 1'b0;
            err_q    <= 1'b0;
            owned_q  <= 1'b0;
`ifdef I2C_TIMING_STRETCH_TIMEOUT_EN
            to_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= cnt_q + CNT_W'(1);
            case (state_q)
                S_IDLE, S_PARK: begin
                    cnt_q <= '0;
                    if (i_cmd_valid) begin
                        mode_q <= i_mode;
                        bit_q  <= i_cmd_bit;
                        if (state_q == S_IDLE) begin
                            if (i_cmd == CMD_START) begin
                                op_q    <= OP_START;
                                state_q <= S_BUF;
                                ready_q <= 1'b0;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            ready_q <= 1'b0;
                            state_q <= S_LOW;
                            case (i_cmd)
                                CMD_START, CMD_RESTART: op_q <= OP_RESTART;
                                CMD_BIT:                op_q <= OP_BIT;
                                CMD_STOP:               op_q <= OP_STOP;
                                default: begin
                                    err_q   <= 1'b1;
                                    ready_q <= 1'b1;
                                    state_q <= S_PARK;
                                end
                            endcase
                        end
                    end
                end
                S_BUF: begin
                    if (cnt_q == t_buf - CNT_W'(1)) begin
                        cnt_q <= '0;
                        if (op_q == OP_START) begin
                            sda_oe_q <= 1'b1;
                            state_q  <= S_HD;
                        end else begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            owned_q <= 1'b0;
                        end
                    end
                end
                S_HD: begin
                    if (cnt_q == t_hd_sta - CNT_W'(1)) begin
                        cnt_q    <= '0;
                        scl_oe_q <= 1'b1;
                        state_q  <= S_PARK;
                        done_q   <= 1'b1;
                        ready_q  <= 1'b1;
                        owned_q  <= 1'b1;
                    end
                end
                S_LOW: begin
                    if (cnt_q == t_hd_dat - CNT_W'(1)) begin
                        case (op_q)
                            OP_BIT:     sda_oe_q <= ~bit_q;
                            OP_RESTART: sda_oe_q <= 1'b0;
                            OP_STOP:    sda_oe_q <= 1'b1;
                            default:    ;
                        endcase
                    end
                    if (cnt_q == t_low - CNT_W'(1)) begin
                        cnt_q    <= '0;
                        scl_oe_q <= 1'b0;
                        state_q  <= S_REL;
`ifdef I2C_TIMING_STRETCH_TIMEOUT_EN
                        to_q     <= '0;
`endif
                    end
                end
                S_REL: begin
                    cnt_q <= '0;
`ifdef I2C_TIMING_STRETCH_TIMEOUT_EN
                    to_q  <= to_q + TO_W'(1);
`endif
                    if (scl_s) begin
                        state_q <= (op_q == OP_BIT) ? S_HIGH : S_SU;
                    end
`ifdef I2C_TIMING_STRETCH_TIMEOUT_EN
                    // Slave never released SCL: abandon the bus.
                    else if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
                        scl_oe_q <= 1'b0;
                        sda_oe_q <= 1'b0;
                        err_q    <= 1'b1;
                        owned_q  <= 1'b0;
                        ready_q  <= 1'b1;
                        state_q  <= S_IDLE;
                    end
`endif
                end
                S_HIGH: begin
                    if (cnt_q == (t_high >> 1)) rx_q <= sda_s;
                    if (cnt_q == t_high - CNT_W'(1)) begin
                        cnt_q    <= '0;
                        scl_oe_q <= 1'b1;
                        state_q  <= S_PARK;
                        done_q   <= 1'b1;
                        ready_q  <= 1'b1;
                    end
                end
                S_SU: begin
                    if (cnt_q == t_su - CNT_W'(1)) begin
                        cnt_q <= '0;
                        if (op_q == OP_STOP) begin
                            sda_oe_q <= 1'b0;
                            state_q  <= S_BUF;
                        end else begin
                            sda_oe_q <= 1'b1;
                            state_q  <= S_HD;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_ready = ready_q;
    assign o_scl_oe    = scl_oe_q;
    assign o_sda_oe    = sda_oe_q;
    assign o_done      = done_q;
    assign o_rx_bit    = rx_q;
    assign o_err       = err_q;
    assign o_bus_owned = owned_q;

endmodule

// File: tb/tb_i2c_bit_timer.sv
// Scoreboarded bench for i2c_bit_timer: open-drain bus model with slave stretch and SDA pull-down.
module tb_i2c_bit_timer;

`ifdef I2C_TIMING_STRETCH_TIMEOUT_EN
    localparam int unsigned TO_CYC = 500;
`else
    localparam int unsigned TO_CYC = 2_500_000;
`endif

    localparam int SEL_SCL  = 0;
    localparam int SEL_SDA  = 1;
    localparam int SEL_DONE = 2;
    localparam int SEL_ERR  = 3;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [1:0] i_mode = 2'b00;
    logic [2:0] i_cmd = 3'd0;
    logic       i_cmd_bit = 1'b0;
    logic       i_cmd_valid = 1'b0;
    logic       o_cmd_ready, o_scl_oe, o_sda_oe, o_done, o_rx_bit, o_err, o_bus_owned;
    logic       i_scl, i_sda;
    logic       stretch = 1'b0;
    logic       slave_low = 1'b0;

    assign i_scl = ~(o_scl_oe | stretch);
    assign i_sda = ~(o_sda_oe | slave_low);

    i2c_bit_timer #(.CLK_HZ(100_000_000), .CNT_W(16), .TIMEOUT_CYC(TO_CYC)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_mode(i_mode), .i_cmd(i_cmd),
        .i_cmd_bit(i_cmd_bit), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_scl(i_scl), .i_sda(i_sda), .o_scl_oe(o_scl_oe), .o_sda_oe(o_sda_oe),
        .o_done(o_done), .o_rx_bit(o_rx_bit), .o_err(o_err), .o_bus_owned(o_bus_owned)
    );

    always #5 i_clk = ~i_clk;

    int unsigned cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        string tag;
        logic  is_err;
        logic  chk_rx;
        logic  rx;
        logic  owned;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_err_pulse = 0;
    int n_done_pulse = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic e, input logic cr, input logic rx, input logic ow);
        exp_t x;
        x.tag = tag; x.is_err = e; x.chk_rx = cr; x.rx = rx; x.owned = ow;
        return x;
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            SEL_SCL:  return o_scl_oe;
            SEL_SDA:  return o_sda_oe;
            SEL_DONE: return o_done;
            default:  return o_err;
        endcase
    endfunction

    // Every completion or error pulse must match the oldest outstanding expectation.
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst && (o_done || o_err)) begin
            if (o_err) n_err_pulse++;
            if (o_done) n_done_pulse++;
            if (sb.size() == 0) begin
                check("sb_unexpected_pulse", 32'(sb.size()), 1);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_done"}, 32'(o_done), 32'(!e.is_err));
                check({e.tag, "_err"}, 32'(o_err), 32'(e.is_err));
                if (e.chk_rx) check({e.tag, "_rx"}, 32'(o_rx_bit), 32'(e.rx));
                check({e.tag, "_owned"}, 32'(o_bus_owned), 32'(e.owned));
                check({e.tag, "_ready"}, 32'(o_cmd_ready), 1);
            end
        end
    end

    task automatic issue(input logic [2:0] c, input logic b, input logic [1:0] m,
                         input exp_t e, output int unsigned t_acc);
        int n = 0;
        while (!o_cmd_ready && n < 20000) begin
            @(negedge i_clk);
            n++;
        end
        check({e.tag, "_ready_wait"}, 32'(o_cmd_ready), 1);
        i_cmd = c; i_cmd_bit = b; i_mode = m; i_cmd_valid = 1'b1;
        sb.push_back(e);
        @(negedge i_clk);
        t_acc = cyc;
        // Scramble inputs after acceptance; the engine must use the latched copy.
        i_cmd_valid = 1'b0; i_cmd = 3'd7; i_cmd_bit = ~b; i_mode = ~m;
    endtask

    task automatic wait_for(input int sel, input logic val, input int budget,
                            input string tag, output int unsigned t);
        int n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (sig(sel) !== val && n < budget);
        t = cyc;
        check({tag, "_seen"}, 32'(sig(sel)), 32'(val));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
        $fatal(1);
    end

    initial begin
        int unsigned ta, t, t2, t3;
        int e0;

        repeat (3) @(negedge i_clk);
        check("rst_scl_oe", 32'(o_scl_oe), 0);
        check("rst_sda_oe", 32'(o_sda_oe), 0);
        check("rst_ready", 32'(o_cmd_ready), 1);
        check("rst_done", 32'(o_done), 0);
        check("rst_rx", 32'(o_rx_bit), 0);
        check("rst_err", 32'(o_err), 0);
        check("rst_owned", 32'(o_bus_owned), 0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // START, standard mode: tBUF then tHD_STA
        issue(3'd0, 1'b0, 2'b00, mk("start_sm", 1'b0, 1'b0, 1'b0, 1'b1), ta);
        wait_for(SEL_SDA, 1'b1, 1000, "start_sda", t);
        check("start_tbuf", t - ta, 470);
        wait_for(SEL_SCL, 1'b1, 1000, "start_scl", t2);
        check("start_thd_sta", t2 - t, 400);

        // BIT=1 fast mode, slave pulls SDA low. Bus high = 3 sync/decision cycles + tHIGH.
        slave_low = 1'b1;
        issue(3'd1, 1'b1, 2'b01, mk("bit_fm_slave", 1'b0, 1'b1, 1'b0, 1'b1), ta);
        wait_for(SEL_SDA, 1'b0, 500, "bit_fm_sda", t);
        check("bit_fm_thd_dat", t - ta, 30);
        wait_for(SEL_SCL, 1'b0, 500, "bit_fm_rel", t);
        check("bit_fm_tlow", t - ta, 130);
        wait_for(SEL_SCL, 1'b1, 500, "bit_fm_high", t2);
        check("bit_fm_thigh", t2 - t, 63);
        slave_low = 1'b0;

        // BIT=0 fast-plus with a 1000-cycle stretch
        e0 = n_err_pulse;
        stretch = 1'b1;
        issue(3'd1, 1'b0, 2'b10, mk("bit_fp_stretch", 1'b0, 1'b1, 1'b0, 1'b1), ta);
        wait_for(SEL_SCL, 1'b0, 500, "bit_fp_rel", t);
        check("bit_fp_tlow", t - ta, 50);
        repeat (1000) @(negedge i_clk);
        check("stretch_holds_rel", 32'(o_scl_oe), 0);
        stretch = 1'b0;
        t = cyc;
        wait_for(SEL_SCL, 1'b1, 500, "bit_fp_high", t2);
        check("bit_fp_thigh_after_stretch", t2 - t, 29);
        check("stretch_no_err", 32'(n_err_pulse), 32'(e0));

        // BIT=1, nobody pulls SDA: reads back 1
        issue(3'd1, 1'b1, 2'b01, mk("bit_rx1", 1'b0, 1'b1, 1'b1, 1'b1), ta);
        wait_for(SEL_DONE, 1'b1, 1000, "bit_rx1_done", t);

        // START while owned behaves as RESTART (fast-plus)
        issue(3'd0, 1'b0, 2'b10, mk("restart_fp", 1'b0, 1'b0, 1'b0, 1'b1), ta);
        wait_for(SEL_SCL, 1'b0, 500, "restart_rel", t);
        check("restart_tlow", t - ta, 50);
        wait_for(SEL_SDA, 1'b1, 500, "restart_sda", t2);
        check("restart_tsu_sta", t2 - t, 29);
        wait_for(SEL_SCL, 1'b1, 500, "restart_scl", t3);
        check("restart_thd_sta", t3 - t2, 26);

        // STOP, standard mode
        issue(3'd3, 1'b0, 2'b00, mk("stop_sm", 1'b0, 1'b0, 1'b0, 1'b0), ta);
        check("stop_sda_held", 32'(o_sda_oe), 1);
        wait_for(SEL_SCL, 1'b0, 1000, "stop_rel", t);
        check("stop_tlow", t - ta, 470);
        wait_for(SEL_SDA, 1'b0, 1000, "stop_sda", t2);
        check("stop_tsu_sto", t2 - t, 403);
        wait_for(SEL_DONE, 1'b1, 1000, "stop_done", t3);
        check("stop_tbuf", t3 - t2, 470);

        // Illegal commands: consumed with an error pulse, no bus activity
        issue(3'd1, 1'b1, 2'b00, mk("bit_in_idle", 1'b1, 1'b0, 1'b0, 1'b0), ta);
        @(negedge i_clk);
        check("err_one_cycle", 32'(o_err), 0);
        check("idle_scl_released", 32'(o_scl_oe), 0);
        check("idle_sda_released", 32'(o_sda_oe), 0);
        issue(3'd5, 1'b0, 2'b00, mk("code5_idle", 1'b1, 1'b0, 1'b0, 1'b0), ta);
        issue(3'd0, 1'b0, 2'b10, mk("start_fp", 1'b0, 1'b0, 1'b0, 1'b1), ta);
        wait_for(SEL_DONE, 1'b1, 1000, "start_fp_done", t);
        issue(3'd6, 1'b0, 2'b10, mk("code6_park", 1'b1, 1'b0, 1'b0, 1'b1), ta);
        @(negedge i_clk);
        check("park_scl_held", 32'(o_scl_oe), 1);
        check("park_ready", 32'(o_cmd_ready), 1);

        // Reset in the middle of HIGH
        issue(3'd1, 1'b0, 2'b00, mk("bit_rst", 1'b0, 1'b0, 1'b0, 1'b1), ta);
        wait_for(SEL_SCL, 1'b0, 1000, "bit_rst_rel", t);
        repeat (100) @(negedge i_clk);
        check("pre_rst_sda_low", 32'(o_sda_oe), 1);
        i_rst = 1'b1;
        #1;
        check("rst_mid_scl", 32'(o_scl_oe), 0);
        check("rst_mid_sda", 32'(o_sda_oe), 0);
        check("rst_mid_ready", 32'(o_cmd_ready), 1);
        check("rst_mid_owned", 32'(o_bus_owned), 0);
        sb.delete();
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        issue(3'd1, 1'b0, 2'b00, mk("bit_after_rst", 1'b1, 1'b0, 1'b0, 1'b0), ta);

`ifdef I2C_TIMING_STRETCH_TIMEOUT_EN
        // Slave holds SCL low forever during REL
        issue(3'd0, 1'b0, 2'b10, mk("start_to", 1'b0, 1'b0, 1'b0, 1'b1), ta);
        wait_for(SEL_DONE, 1'b1, 1000, "start_to_done", t);
        stretch = 1'b1;
        e0 = n_done_pulse;
        issue(3'd1, 1'b0, 2'b10, mk("timeout", 1'b1, 1'b0, 1'b0, 1'b0), ta);
        wait_for(SEL_SCL, 1'b0, 500, "timeout_rel", t);
        wait_for(SEL_ERR, 1'b1, 1000, "timeout_err", t2);
        check("timeout_cycles", t2 - t, 500);
        check("timeout_scl_rel", 32'(o_scl_oe), 0);
        check("timeout_sda_rel", 32'(o_sda_oe), 0);
        @(negedge i_clk);
        check("timeout_no_done", 32'(n_done_pulse), 32'(e0));
        stretch = 1'b0;
`endif

        repeat (5) @(negedge i_clk);
        check("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
